// File: rtl/star_vector_accumulator.sv
// STAR vector producer: accumulates l = sum(p) and O[i] = sum(p*V[i]) per row,
// then presents {l, O[1..VEC_LEN]} to the vector division stage over valid/ready.
module star_vector_accumulator #(
   parameter int VEC_LEN   = 4,
   parameter int V_WIDTH   = 8,
   parameter int P_WIDTH   = 16,
   parameter int P_F       = 8,
   parameter int ACC_WIDTH = 32,
   parameter int MAX_KEYS  = 64
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             vld_in,
   output logic                             rdy_out,
   input  logic [P_WIDTH-1:0]               p_in,
   input  logic [VEC_LEN*V_WIDTH-1:0]       v_in,
   input  logic                             last_in,
   output logic                             vld_out,
   input  logic                             rdy_in,
   output logic [(VEC_LEN+1)*ACC_WIDTH-1:0] vec_out,
   output logic                             sat_flag
);

   localparam int PW = P_WIDTH + V_WIDTH + 1;
   localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;
   localparam int CW = $clog2(MAX_KEYS + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_KEYS - 1);
   localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

   if (MAX_KEYS < 1 || P_F > P_WIDTH) begin : g_bad_params
      $error("star_vector_accumulator: MAX_KEYS must be >= 1 and P_F <= P_WIDTH");
   end

   typedef enum logic {ACCUM, EMIT} state_t;

   state_t                          state_q, state_d;
   logic [VEC_LEN:0][ACC_WIDTH-1:0] acc_q, acc_d, acc_sum;
   logic [CW-1:0]                   count_q, count_d;
   logic                            sat_q, sat_d;
   logic                            vld_q, vld_d;
   logic                            accept;
   logic                            sat_any;
   logic signed [SW-1:0]            l_sum, o_sum;
   logic signed [PW-1:0]            v_ext, prod;

   assign rdy_out  = (state_q == ACCUM) && reset;
   assign accept   = vld_in && rdy_out;
   assign vld_out  = vld_q;
   assign vec_out  = acc_q;
   assign sat_flag = sat_q;

   // Widen to SW bits so every sum is exact before clamping back to ACC_WIDTH.
   always_comb begin
      acc_sum = acc_q;
      sat_any = 1'b0;
      v_ext   = '0;
      prod    = '0;
      o_sum   = '0;
      l_sum   = {{(SW-ACC_WIDTH){acc_q[0][ACC_WIDTH-1]}}, acc_q[0]}
              + {{(SW-P_WIDTH){1'b0}}, p_in};
      if (l_sum > ACC_MAX) begin
         acc_sum[0] = ACC_MAX[ACC_WIDTH-1:0];
         sat_any    = 1'b1;
      end else begin
         acc_sum[0] = l_sum[ACC_WIDTH-1:0];
      end
      for (int i = 0; i < VEC_LEN; i++) begin
         v_ext = {{(P_WIDTH+1){v_in[i*V_WIDTH+V_WIDTH-1]}}, v_in[i*V_WIDTH +: V_WIDTH]};
         prod  = $signed({{(V_WIDTH+1){1'b0}}, p_in}) * v_ext;
         o_sum = {{(SW-ACC_WIDTH){acc_q[i+1][ACC_WIDTH-1]}}, acc_q[i+1]}
               + {{(SW-PW){prod[PW-1]}}, prod};
         if (o_sum > ACC_MAX) begin
            acc_sum[i+1] = ACC_MAX[ACC_WIDTH-1:0];
            sat_any      = 1'b1;
         end else if (o_sum < ACC_MIN) begin
            acc_sum[i+1] = ACC_MIN[ACC_WIDTH-1:0];
            sat_any      = 1'b1;
         end else begin
            acc_sum[i+1] = o_sum[ACC_WIDTH-1:0];
         end
      end
   end

   // A row ends on last_in or on the MAX_KEYS-th beat; the handshake clears everything.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      sat_d   = sat_q;
      vld_d   = vld_q;
      case (state_q)
         ACCUM: begin
            if (accept) begin
               acc_d   = acc_sum;
               count_d = count_q + CW'(1);
               sat_d   = sat_q | sat_any;
               if (last_in || count_q == LAST_CNT) begin
                  state_d = EMIT;
                  vld_d   = 1'b1;
               end
            end
         end
         EMIT: begin
            if (vld_q && rdy_in) begin
               acc_d   = '0;
               count_d = '0;
               sat_d   = 1'b0;
               vld_d   = 1'b0;
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         count_q <= '0;
         sat_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         sat_q   <= sat_d;
         vld_q   <= vld_d;
      end
   end

endmodule

// File: tb/tb_star_vector_accumulator.sv
// Directed bench for star_vector_accumulator with VEC_LEN=4, V_WIDTH=8, ACC_WIDTH=24, MAX_KEYS=4.
module tb_star_vector_accumulator;

   logic         clock = 1'b0;
   logic         reset;
   logic         vld_in;
   logic         rdy_out;
   logic [15:0]  p_in;
   logic [31:0]  v_in;
   logic         last_in;
   logic         vld_out;
   logic         rdy_in;
   logic [119:0] vec_out;
   logic         sat_flag;

   int checks = 0;
   int errors = 0;

   star_vector_accumulator #(
      .VEC_LEN(4), .V_WIDTH(8), .P_WIDTH(16), .P_F(8), .ACC_WIDTH(24), .MAX_KEYS(4)
   ) dut (
      .clock(clock), .reset(reset), .vld_in(vld_in), .rdy_out(rdy_out),
      .p_in(p_in), .v_in(v_in), .last_in(last_in), .vld_out(vld_out),
      .rdy_in(rdy_in), .vec_out(vec_out), .sat_flag(sat_flag)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_beat(input int p, input int a, input int b, input int c, input int d,
                            input bit last);
      vld_in  = 1'b1;
      p_in    = 16'(p);
      v_in    = {8'(d), 8'(c), 8'(b), 8'(a)};
      last_in = last;
      tick();
      vld_in  = 1'b0;
      last_in = 1'b0;
   endtask

   task automatic test_reset();
      int exp [5] = '{0, 0, 0, 0, 0};
      logic signed [23:0] got;
      reset = 1'b0; vld_in = 1'b0; p_in = '0; v_in = '0; last_in = 1'b0; rdy_in = 1'b0;
      tick();
      tick();
      checks++;
      if (vld_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_vld got %b expected 0", vld_out); end
      checks++;
      if (rdy_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_rdy got %b expected 0", rdy_out); end
      checks++;
      if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL rst_sat got %b expected 0", sat_flag); end
      for (int i = 0; i < 5; i++) begin
         got = vec_out[i*24 +: 24];
         checks++;
         if (int'(got) !== exp[i]) begin
            errors++; $display("[TB] FAIL rst_vec[%0d] got %0d expected %0d", i, int'(got), exp[i]);
         end
      end
      reset = 1'b1;
      #1;
      checks++;
      if (rdy_out !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_rdy got %b expected 1", rdy_out); end
   endtask

   task automatic test_single_beat();
      int exp [5] = '{256, 256, 512, 768, 1024};
      logic signed [23:0] got;
      rdy_in = 1'b1;
      send_beat(16'h0100, 1, 2, 3, 4, 1'b1);
      checks++;
      if (vld_out !== 1'b1) begin errors++; $display("[TB] FAIL t1_vld got %b expected 1", vld_out); end
      checks++;
      if (rdy_out !== 1'b0) begin errors++; $display("[TB] FAIL t1_rdy got %b expected 0", rdy_out); end
      for (int i = 0; i < 5; i++) begin
         got = vec_out[i*24 +: 24];
         checks++;
         if (int'(got) !== exp[i]) begin
            errors++; $display("[TB] FAIL t1_vec[%0d] got %0d expected %0d", i, int'(got), exp[i]);
         end
      end
      checks++;
      if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL t1_sat got %b expected 0", sat_flag); end
      tick();
      checks++;
      if (vld_out !== 1'b0) begin errors++; $display("[TB] FAIL t1_post_vld got %b expected 0", vld_out); end
      checks++;
      if (rdy_out !== 1'b1) begin errors++; $display("[TB] FAIL t1_post_rdy got %b expected 1", rdy_out); end
      got = vec_out[0 +: 24];
      checks++;
      if (int'(got) !== 0) begin errors++; $display("[TB] FAIL t1_post_l got %0d expected 0", int'(got)); end
   endtask

   task automatic test_negatives_gaps();
      int exp [5] = '{512, -128, 1280, -49152, 16640};
      logic signed [23:0] got;
      rdy_in = 1'b1;
      send_beat(16'h0080, 2, -2, 0, 127, 1'b0);
      checks++;
      if (vld_out !== 1'b0) begin errors++; $display("[TB] FAIL t2_mid_vld got %b expected 0", vld_out); end
      vld_in = 1'b0; p_in = 16'hFFFF; v_in = 32'h7F7F7F7F; last_in = 1'b1;
      tick();
      send_beat(16'h0180, -1, 4, -128, 1, 1'b1);
      checks++;
      if (vld_out !== 1'b1) begin errors++; $display("[TB] FAIL t2_vld got %b expected 1", vld_out); end
      for (int i = 0; i < 5; i++) begin
         got = vec_out[i*24 +: 24];
         checks++;
         if (int'(got) !== exp[i]) begin
            errors++; $display("[TB] FAIL t2_vec[%0d] got %0d expected %0d", i, int'(got), exp[i]);
         end
      end
      tick();
   endtask

   task automatic test_backpressure();
      int exp  [5] = '{512, 512, -512, 1024, -1024};
      int exp2 [5] = '{256, 1280, 1536, 1792, 2048};
      logic signed [23:0] got;
      rdy_in = 1'b0;
      send_beat(16'h0200, 1, -1, 2, -2, 1'b1);
      vld_in = 1'b1; p_in = 16'h0100; v_in = {8'd8, 8'd7, 8'd6, 8'd5}; last_in = 1'b1;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (vld_out !== 1'b1) begin errors++; $display("[TB] FAIL t3_hold_vld[%0d] got %b expected 1", c, vld_out); end
         checks++;
         if (rdy_out !== 1'b0) begin errors++; $display("[TB] FAIL t3_hold_rdy[%0d] got %b expected 0", c, rdy_out); end
         for (int i = 0; i < 5; i++) begin
            got = vec_out[i*24 +: 24];
            checks++;
            if (int'(got) !== exp[i]) begin
               errors++; $display("[TB] FAIL t3_hold_vec[%0d][%0d] got %0d expected %0d", c, i, int'(got), exp[i]);
            end
         end
         tick();
      end
      rdy_in = 1'b1;
      tick();
      checks++;
      if (vld_out !== 1'b0) begin errors++; $display("[TB] FAIL t3_hs_vld got %b expected 0", vld_out); end
      got = vec_out[0 +: 24];
      checks++;
      if (int'(got) !== 0) begin errors++; $display("[TB] FAIL t3_hs_l got %0d expected 0", int'(got)); end
      tick();
      vld_in = 1'b0; last_in = 1'b0;
      checks++;
      if (vld_out !== 1'b1) begin errors++; $display("[TB] FAIL t3_next_vld got %b expected 1", vld_out); end
      for (int i = 0; i < 5; i++) begin
         got = vec_out[i*24 +: 24];
         checks++;
         if (int'(got) !== exp2[i]) begin
            errors++; $display("[TB] FAIL t3_next_vec[%0d] got %0d expected %0d", i, int'(got), exp2[i]);
         end
      end
      tick();
   endtask

   task automatic test_max_keys();
      int exp  [5] = '{1024, 1024, 1024, 1024, 1024};
      int exp2 [5] = '{256, 512, 0, 0, 0};
      logic signed [23:0] got;
      rdy_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         send_beat(16'h0100, 1, 1, 1, 1, 1'b0);
         checks++;
         if (vld_out !== 1'b0) begin errors++; $display("[TB] FAIL t4_early_vld[%0d] got %b expected 0", k, vld_out); end
      end
      send_beat(16'h0100, 1, 1, 1, 1, 1'b0);
      checks++;
      if (vld_out !== 1'b1) begin errors++; $display("[TB] FAIL t4_vld got %b expected 1", vld_out); end
      for (int i = 0; i < 5; i++) begin
         got = vec_out[i*24 +: 24];
         checks++;
         if (int'(got) !== exp[i]) begin
            errors++; $display("[TB] FAIL t4_vec[%0d] got %0d expected %0d", i, int'(got), exp[i]);
         end
      end
      tick();
      send_beat(16'h0100, 2, 0, 0, 0, 1'b1);
      checks++;
      if (vld_out !== 1'b1) begin errors++; $display("[TB] FAIL t4_new_vld got %b expected 1", vld_out); end
      for (int i = 0; i < 5; i++) begin
         got = vec_out[i*24 +: 24];
         checks++;
         if (int'(got) !== exp2[i]) begin
            errors++; $display("[TB] FAIL t4_new_vec[%0d] got %0d expected %0d", i, int'(got), exp2[i]);
         end
      end
      tick();
   endtask

   task automatic test_saturation();
      int exp [5] = '{262140, 8388607, -8388608, 0, 0};
      logic signed [23:0] got;
      rdy_in = 1'b1;
      send_beat(16'hFFFF, 127, -128, 0, 0, 1'b0);
      checks++;
      if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL t5_sat_first got %b expected 0", sat_flag); end
      send_beat(16'hFFFF, 127, -128, 0, 0, 1'b0);
      checks++;
      if (sat_flag !== 1'b1) begin errors++; $display("[TB] FAIL t5_sat_second got %b expected 1", sat_flag); end
      send_beat(16'hFFFF, 127, -128, 0, 0, 1'b0);
      send_beat(16'hFFFF, 127, -128, 0, 0, 1'b0);
      checks++;
      if (vld_out !== 1'b1) begin errors++; $display("[TB] FAIL t5_vld got %b expected 1", vld_out); end
      checks++;
      if (sat_flag !== 1'b1) begin errors++; $display("[TB] FAIL t5_sat_emit got %b expected 1", sat_flag); end
      for (int i = 0; i < 5; i++) begin
         got = vec_out[i*24 +: 24];
         checks++;
         if (int'(got) !== exp[i]) begin
            errors++; $display("[TB] FAIL t5_vec[%0d] got %0d expected %0d", i, int'(got), exp[i]);
         end
      end
      tick();
      checks++;
      if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL t5_sat_after got %b expected 0", sat_flag); end
   endtask

   task automatic test_reset_mid();
      int exp  [5] = '{256, 256, 512, 768, 1024};
      int exp2 [5] = '{256, 2304, 0, 0, 0};
      logic signed [23:0] got;
      rdy_in = 1'b0;
      send_beat(16'h0100, 1, 1, 1, 1, 1'b0);
      reset = 1'b0;
      #1;
      checks++;
      if (rdy_out !== 1'b0) begin errors++; $display("[TB] FAIL t6_rdy_low got %b expected 0", rdy_out); end
      tick();
      checks++;
      if (vld_out !== 1'b0) begin errors++; $display("[TB] FAIL t6_vld_low got %b expected 0", vld_out); end
      got = vec_out[24 +: 24];
      checks++;
      if (int'(got) !== 0) begin errors++; $display("[TB] FAIL t6_o1_low got %0d expected 0", int'(got)); end
      reset = 1'b1;
      send_beat(16'h0100, 1, 2, 3, 4, 1'b1);
      for (int i = 0; i < 5; i++) begin
         got = vec_out[i*24 +: 24];
         checks++;
         if (int'(got) !== exp[i]) begin
            errors++; $display("[TB] FAIL t6_row_vec[%0d] got %0d expected %0d", i, int'(got), exp[i]);
         end
      end
      reset = 1'b0;
      tick();
      checks++;
      if (vld_out !== 1'b0) begin errors++; $display("[TB] FAIL t6_emit_vld got %b expected 0", vld_out); end
      checks++;
      if (rdy_out !== 1'b0) begin errors++; $display("[TB] FAIL t6_emit_rdy got %b expected 0", rdy_out); end
      got = vec_out[0 +: 24];
      checks++;
      if (int'(got) !== 0) begin errors++; $display("[TB] FAIL t6_emit_l got %0d expected 0", int'(got)); end
      reset = 1'b1;
      send_beat(16'h0100, 9, 0, 0, 0, 1'b1);
      checks++;
      if (vld_out !== 1'b1) begin errors++; $display("[TB] FAIL t6_fresh_vld got %b expected 1", vld_out); end
      for (int i = 0; i < 5; i++) begin
         got = vec_out[i*24 +: 24];
         checks++;
         if (int'(got) !== exp2[i]) begin
            errors++; $display("[TB] FAIL t6_fresh_vec[%0d] got %0d expected %0d", i, int'(got), exp2[i]);
         end
      end
      rdy_in = 1'b1;
      tick();
      checks++;
      if (vld_out !== 1'b0) begin errors++; $display("[TB] FAIL t6_final_vld got %b expected 0", vld_out); end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_negatives_gaps();
      test_backpressure();
      test_max_keys();
      test_saturation();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
